// File: rtl/adc_current_seq.sv
// Round-robin scheduler sharing one current-sense ADC across NUM_CH channels,
// with per-channel debounced over-limit faults and a conversion-timeout fault.
module adc_current_seq #(
  parameter int CH_W       = 2,
  parameter int DATA_W     = 16,
  parameter int DEBOUNCE   = 3,
  parameter int TIMEOUT    = 1024,
  parameter int GAP_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           enable,
  input  logic                           clear_fail,
  input  logic [(2**CH_W)*DATA_W-1:0]    ch_limit,
  output logic                           adc_start,
  output logic [CH_W-1:0]                adc_ch,
  input  logic                           adc_done,
  input  logic [DATA_W-1:0]              adc_data,
  output logic                           sample_valid,
  output logic [CH_W-1:0]                sample_ch,
  output logic [DATA_W-1:0]              sample_data,
  output logic [(2**CH_W)-1:0]           fail_flags,
  output logic                           timeout_fail,
  output logic                           any_fail
);
  localparam int NUM_CH = 2**CH_W;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int CNT_W  = $clog2(DEBOUNCE + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT, CHECK, GAP} state_t;

  state_t              state_reg, state_next;
  logic [CH_W-1:0]     ch_reg, ch_next;
  logic [TMR_W-1:0]    timer_reg, timer_next;
  logic [GAP_W-1:0]    gap_reg, gap_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                check_en;
  logic                timeout_set;
  logic                advance;
  logic [NUM_CH-1:0]   fail_set;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      ch_reg    <= '0;
      timer_reg <= '0;
      gap_reg   <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
      timer_reg <= timer_next;
      gap_reg   <= gap_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ch_next     = ch_reg;
    timer_next  = timer_reg;
    gap_next    = gap_reg;
    data_next   = data_reg;
    adc_start   = 1'b0;
    check_en    = 1'b0;
    timeout_set = 1'b0;
    advance     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable) begin
          ch_next    = '0;
          state_next = START;
        end
      end
      START: begin
        adc_start  = 1'b1;
        timer_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (adc_done) begin
          data_next  = adc_data;
          state_next = CHECK;
        end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
          // A dead ADC skips this slot rather than stalling the whole scan.
          timeout_set = 1'b1;
          advance     = 1'b1;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      CHECK: begin
        check_en = 1'b1;
        advance  = 1'b1;
      end
      GAP: begin
        if (gap_reg == GAP_W'(GAP_CYCLES - 1)) begin
          gap_next   = '0;
          ch_next    = '0;
          state_next = enable ? START : IDLE;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (advance) begin
      if (!enable) begin
        state_next = IDLE;
        ch_next    = '0;
      end else if (ch_reg == CH_W'(NUM_CH - 1)) begin
        state_next = GAP;
        gap_next   = '0;
      end else begin
        ch_next    = ch_reg + 1'b1;
        state_next = START;
      end
    end
  end

  assign adc_ch = ch_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             hit;
      logic             over;

      assign hit  = check_en && (ch_reg == CH_W'(gi));
      assign over = data_reg > ch_limit[gi*DATA_W +: DATA_W];

      // The check update is computed from the pre-clear count so a fault
      // reaching DEBOUNCE in the same cycle as clear_fail still latches.
      always_comb begin
        cnt_next = clear_fail ? '0 : cnt_reg;
        if (hit) begin
          if (!over)
            cnt_next = '0;
          else if (cnt_reg == CNT_W'(DEBOUNCE))
            cnt_next = CNT_W'(DEBOUNCE);
          else
            cnt_next = cnt_reg + 1'b1;
        end
      end

      assign fail_set[gi] = hit && over && (cnt_next == CNT_W'(DEBOUNCE));

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
          cnt_reg <= '0;
        else
          cnt_reg <= cnt_next;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      fail_flags   <= '0;
      timeout_fail <= 1'b0;
      any_fail     <= 1'b0;
    end else begin
      sample_valid <= check_en;
      if (check_en) begin
        sample_ch   <= ch_reg;
        sample_data <= data_reg;
      end
      fail_flags   <= fail_set | (fail_flags & ~{NUM_CH{clear_fail}});
      timeout_fail <= timeout_set | (timeout_fail & ~clear_fail);
      any_fail     <= (|fail_flags) | timeout_fail;
    end
  end

endmodule

// File: tb/tb_adc_current_seq.sv
// Directed bench for adc_current_seq: an ADC responder issues scripted results
// and queues the expected samples; a monitor checks each sample_valid pulse.
module tb_adc_current_seq;
  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        clear_fail;
  logic [63:0] ch_limit;
  logic        adc_start;
  logic [1:0]  adc_ch;
  logic        adc_done;
  logic [15:0] adc_data;
  logic        sample_valid;
  logic [1:0]  sample_ch;
  logic [15:0] sample_data;
  logic [3:0]  fail_flags;
  logic        timeout_fail;
  logic        any_fail;

  int n_checks  = 0;
  int n_pass    = 0;
  int cyc       = 0;
  int n_starts  = 0;
  int n_samples = 0;
  int exp_ch    = 0;

  logic [17:0] exp_q[$];
  logic [15:0] tab [4][16];
  int          wr [4];
  int          rd [4];
  int          skip [4];

  adc_current_seq dut (
    .clk(clk), .rstn(rstn), .enable(enable), .clear_fail(clear_fail),
    .ch_limit(ch_limit), .adc_start(adc_start), .adc_ch(adc_ch),
    .adc_done(adc_done), .adc_data(adc_data), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample_data(sample_data), .fail_flags(fail_flags),
    .timeout_fail(timeout_fail), .any_fail(any_fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic push(input int c, input logic [15:0] v);
    tab[c][wr[c]] = v;
    wr[c]++;
  endtask

  task automatic wait_sample(input int c);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (sample_valid && sample_ch == 2'(c)) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL wait_sample: no sample for ch %0d within 400 cycles, required one", c);
    end
  endtask

  task automatic wait_start_ch(input int c, output int t);
    bit seen = 0;
    t = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (adc_start && adc_ch == 2'(c)) begin
        seen = 1;
        t = cyc;
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL wait_start: no adc_start for ch %0d within 400 cycles, required one", c);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_fail = 1'b1;
    @(negedge clk);
    clear_fail = 1'b0;
  endtask

  // ADC model: answers 4 negedges after each start, or stays silent when a skip is queued.
  initial begin
    int c;
    logic [15:0] v;
    adc_done = 1'b0;
    adc_data = '0;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && adc_start) begin
        c = exp_ch;
        n_starts++;
        check("adc_ch", 32'(adc_ch), 32'(c));
        exp_ch = (exp_ch + 1) % 4;
        if (skip[c] > 0) begin
          skip[c]--;
        end else begin
          v = 16'h0800;
          if (rd[c] < wr[c]) begin
            v = tab[c][rd[c]];
            rd[c]++;
          end
          repeat (4) @(negedge clk);
          adc_done = 1'b1;
          adc_data = v;
          if (rstn) exp_q.push_back({2'(c), v});
          @(negedge clk);
          adc_done = 1'b0;
          adc_data = '0;
        end
      end
    end
  end

  // Monitor: one line per checked sample.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && sample_valid) begin
        n_samples++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_sample: got ch %0d data 0x%h, required no sample", sample_ch, sample_data);
        end else begin
          e = exp_q.pop_front();
          check("sample_ch", 32'(sample_ch), 32'(e[17:16]));
          check("sample_data", 32'(sample_data), 32'(e[15:0]));
          $display("sample ch=%0d data=0x%h flags=%b timeout=%b", sample_ch, sample_data, fail_flags, timeout_fail);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3, t4, ts, ns, el;
    bit seen;
    for (int i = 0; i < 4; i++) begin
      wr[i] = 0; rd[i] = 0; skip[i] = 0;
    end
    rstn = 1'b0; enable = 1'b0; clear_fail = 1'b0;
    ch_limit = {4{16'h1000}};
    repeat (3) @(negedge clk);
    check("rst_adc_start", 32'(adc_start), 0);
    check("rst_sample_valid", 32'(sample_valid), 0);
    check("rst_fail_flags", 32'(fail_flags), 0);
    check("rst_timeout_fail", 32'(timeout_fail), 0);
    check("rst_any_fail", 32'(any_fail), 0);
    rstn = 1'b1;
    @(negedge clk);
    enable = 1'b1;

    // Round 1: nominal scan order and inter-round gap.
    wait_start_ch(0, t0);
    wait_start_ch(1, t1);
    wait_start_ch(2, t2);
    wait_start_ch(3, t3);
    wait_start_ch(0, t4);
    check("start_interval_01", 32'(t1 - t0), 6);
    check("start_interval_12", 32'(t2 - t1), 6);
    check("start_interval_23", 32'(t3 - t2), 6);
    check("start_interval_gap", 32'(t4 - t3), 22);
    check("round_samples", 32'(n_samples), 4);
    check("nominal_flags", 32'(fail_flags), 0);

    // Channel 2 over limit for three rounds.
    @(posedge clk);
    repeat (3) push(2, 16'h1001);
    wait_sample(2);
    wait_sample(2);
    check("ch2_two_over_flags", 32'(fail_flags), 0);
    wait_sample(2);
    check("ch2_third_over_flags", 32'(fail_flags), 32'h4);
    check("ch2_any_fail_lag", 32'(any_fail), 0);
    @(negedge clk);
    check("ch2_any_fail", 32'(any_fail), 1);

    pulse_clear();
    check("clear_flags", 32'(fail_flags), 0);
    @(negedge clk);
    check("clear_any_fail", 32'(any_fail), 0);

    // Channel 2 exactly at the limit never faults.
    wait_sample(2);
    @(posedge clk);
    repeat (3) push(2, 16'h1000);
    repeat (4) wait_sample(2);
    check("ch2_equal_flags", 32'(fail_flags), 0);

    // Channel 1: over, over, under, over, over, over.
    wait_sample(1);
    @(posedge clk);
    push(1, 16'h1001); push(1, 16'h1001); push(1, 16'h0fff);
    push(1, 16'h1001); push(1, 16'h1001); push(1, 16'h1001);
    repeat (5) wait_sample(1);
    check("ch1_broken_run_flags", 32'(fail_flags), 0);
    wait_sample(1);
    check("ch1_third_over_flags", 32'(fail_flags), 32'h2);

    // Channel 0 never answers: timeout and skip to channel 1.
    pulse_clear();
    check("clear2_flags", 32'(fail_flags), 0);
    @(posedge clk);
    skip[0] = 1;
    wait_start_ch(0, ts);
    seen = 0;
    el = 0;
    for (int i = 1; i <= 1100 && !seen; i++) begin
      @(negedge clk);
      if (timeout_fail) begin
        seen = 1;
        el = i;
      end
    end
    check("timeout_latency", 32'(el), 1025);
    check("timeout_next_start", 32'(adc_start), 1);
    check("timeout_next_ch", 32'(adc_ch), 1);
    check("timeout_no_flags", 32'(fail_flags), 0);

    pulse_clear();
    check("clear_timeout", 32'(timeout_fail), 0);

    // Channel 3 reaches DEBOUNCE in the same cycle clear_fail is high.
    wait_sample(3);
    @(posedge clk);
    repeat (3) push(3, 16'h2000);
    wait_sample(3);
    wait_sample(3);
    wait_start_ch(3, ts);
    repeat (5) @(negedge clk);
    clear_fail = 1'b1;
    @(negedge clk);
    clear_fail = 1'b0;
    check("set_wins_valid", 32'(sample_valid), 1);
    check("set_wins_flags", 32'(fail_flags), 32'h8);
    @(negedge clk);
    check("set_wins_any_fail", 32'(any_fail), 1);
    pulse_clear();
    check("late_clear_flags", 32'(fail_flags), 0);
    @(negedge clk);
    check("late_clear_any_fail", 32'(any_fail), 0);

    // Drop enable while channel 1 is converting.
    wait_start_ch(1, ts);
    @(negedge clk);
    enable = 1'b0;
    wait_sample(1);
    ns = n_starts;
    repeat (40) @(negedge clk);
    check("disabled_no_start", 32'(n_starts), 32'(ns));
    check("disabled_adc_ch", 32'(adc_ch), 0);

    // Reset in the middle of a channel-1 conversion.
    exp_ch = 0;
    enable = 1'b1;
    wait_start_ch(0, ts);
    wait_start_ch(1, ts);
    @(negedge clk);
    enable = 1'b0;
    rstn = 1'b0;
    #1;
    check("mid_rst_adc_start", 32'(adc_start), 0);
    check("mid_rst_adc_ch", 32'(adc_ch), 0);
    check("mid_rst_sample_data", 32'(sample_data), 0);
    check("mid_rst_sample_valid", 32'(sample_valid), 0);
    check("mid_rst_flags", 32'({fail_flags, timeout_fail, any_fail}), 0);
    ns = n_starts;
    repeat (10) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_no_start", 32'(n_starts), 32'(ns));
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
